// File: rtl/fmap_pingpong_bank_pkg.sv
// Shared types and default geometry for the feature-map ping-pong buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fmap_pingpong_bank_pkg;

  // Ownership state of one bank: the writer owns EMPTY/FILLING, the reader owns FULL.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_LANES  = 64;
  localparam int DEF_DEPTH  = 12321;  // 111 x 111 output map

endpackage

// File: rtl/fmap_pingpong_bank_if.sv
// Bus bundle between a feature-map producer/consumer (master) and the ping-pong buffer (slave).
// Latency: n/a (wiring only).
// Backpressure: wr_ready / rd_ready are driven by the slave; clear_busy blocks both directions.
interface fmap_pingpong_bank_if
  import fmap_pingpong_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) ();

  logic                      clear_req;
  logic                      clear_busy;

  logic                      wr_valid;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W*LANES-1:0]   wr_data;
  logic [LANES-1:0]          wr_mask;
  logic                      wr_last;

  logic                      rd_en;
  logic                      rd_ready;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      rd_valid;
  logic [DATA_W*LANES-1:0]   rd_data;
  logic                      rd_done;

  logic                      addr_err;

  modport master (
    output clear_req, wr_valid, wr_addr, wr_data, wr_mask, wr_last, rd_en, rd_addr, rd_done,
    input  clear_busy, wr_ready, rd_ready, rd_valid, rd_data, addr_err
  );

  modport slave (
    input  clear_req, wr_valid, wr_addr, wr_data, wr_mask, wr_last, rd_en, rd_addr, rd_done,
    output clear_busy, wr_ready, rd_ready, rd_valid, rd_data, addr_err
  );

endinterface

// File: rtl/fmap_bank_ram.sv
// One bank: DEPTH rows of LANES words, lane-masked write port, registered read port.
// Latency: rdata valid one cycle after re; rdata holds when re is low.
// Backpressure: none, the caller guarantees legal addresses and enables.
module fmap_bank_ram
  import fmap_pingpong_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int ROW_W  = DATA_W * LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ROW_W-1:0]  wdata,
  input  logic [LANES-1:0]  wmask,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [ROW_W-1:0]  rdata
);

  // Storage has no reset; zeroing is a deliberate sweep driven from the top.
  logic [LANES-1:0][DATA_W-1:0] mem [DEPTH];

  logic [ROW_W-1:0] rdata_q, rdata_d;

  // Per-lane write so unmasked lanes keep their previous contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we && wmask[i]) begin
        mem[waddr][i] <= wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next read register value: new row on a read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Read output register; reset to zero so the bus starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fmap_pingpong_bank.sv
// Ping-pong feature-map buffer: writer fills one bank while the reader drains the other.
// Latency: rd_valid/rd_data one cycle after an accepted rd_en; clear sweep takes DEPTH cycles.
// Backpressure: wr_ready low while the write bank is FULL, rd_ready low unless the read bank is FULL; both low while clearing.
module fmap_pingpong_bank
  import fmap_pingpong_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  fmap_pingpong_bank_if.slave bus
);

  localparam int ROW_W = DATA_W * LANES;
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  bank_state_e       st_q [2];
  bank_state_e       st_d [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_bank_q, rd_bank_d;

  logic wr_ready, rd_ready;
  logic wr_in_rng, rd_in_rng;
  logic wr_acc, rd_acc;
  logic wr_fire, rd_fire, done_fire;

  // A clear_req cycle aborts whatever handshake is presented alongside it.
  assign wr_ready  = (st_q[wptr_q] != FULL) && !busy_q;
  assign rd_ready  = (st_q[rptr_q] == FULL) && !busy_q;
  assign wr_in_rng = {1'b0, bus.wr_addr} < DEPTH_V;
  assign rd_in_rng = {1'b0, bus.rd_addr} < DEPTH_V;
  assign wr_acc    = bus.wr_valid && wr_ready && !bus.clear_req;
  assign rd_acc    = bus.rd_en && rd_ready && !bus.clear_req;
  assign wr_fire   = wr_acc && wr_in_rng;
  assign rd_fire   = rd_acc && rd_in_rng;
  assign done_fire = bus.rd_done && rd_ready && !bus.clear_req;

  // Bank ownership, pointers, clear sweep and sticky error.
  always_comb begin
    st_d      = st_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_vld_d  = rd_fire;
    rd_bank_d = rd_fire ? rptr_q : rd_bank_q;

    if (bus.clear_req) begin
      st_d[0] = EMPTY;
      st_d[1] = EMPTY;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      busy_d  = 1'b1;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (busy_q) begin
      if (cnt_q == LAST_ROW) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if ((wr_acc && !wr_in_rng) || (rd_acc && !rd_in_rng)) begin
        err_d = 1'b1;
      end
      // Write and release always target different banks, so both may land together.
      if (wr_fire) begin
        if (bus.wr_last) begin
          st_d[wptr_q] = FULL;
          wptr_d       = ~wptr_q;
        end else begin
          st_d[wptr_q] = FILLING;
        end
      end
      if (done_fire) begin
        st_d[rptr_q] = EMPTY;
        rptr_d       = ~rptr_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]   <= EMPTY;
      st_q[1]   <= EMPTY;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rd_vld_q  <= rd_vld_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  logic [1:0]        ram_we;
  logic [1:0]        ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ROW_W-1:0]  ram_wdata;
  logic [LANES-1:0]  ram_wmask;
  logic [ROW_W-1:0]  ram_rdata [2];

  // The clear sweep owns both write ports; otherwise only the write bank is enabled.
  always_comb begin
    ram_we    = '0;
    ram_waddr = bus.wr_addr;
    ram_wdata = bus.wr_data;
    ram_wmask = bus.wr_mask;
    if (busy_q) begin
      ram_we    = 2'b11;
      ram_waddr = cnt_q;
      ram_wdata = '0;
      ram_wmask = '1;
    end else begin
      ram_we[wptr_q] = wr_fire;
    end
  end

  assign ram_re[0] = rd_fire && (rptr_q == 1'b0);
  assign ram_re[1] = rd_fire && (rptr_q == 1'b1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fmap_bank_ram #(
      .DATA_W(DATA_W),
      .LANES (LANES),
      .DEPTH (DEPTH)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (ram_we[b]),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .wmask(ram_wmask),
      .re   (ram_re[b]),
      .raddr(bus.rd_addr),
      .rdata(ram_rdata[b])
    );
  end

  // Each bank's read register holds between reads, so selecting the last-read bank holds rd_data.
  assign bus.rd_data    = ram_rdata[rd_bank_q];
  assign bus.rd_valid   = rd_vld_q;
  assign bus.wr_ready   = wr_ready;
  assign bus.rd_ready   = rd_ready;
  assign bus.clear_busy = busy_q;
  assign bus.addr_err   = err_q;

endmodule

// File: tb/tb_fmap_pingpong_bank.sv
// Self-checking bench for fmap_pingpong_bank with a scoreboard of expected read rows.
// Latency: expects rd_valid one clock after each accepted rd_en.
// Backpressure: exercises full/empty ready gating and the clear sweep.
module tb_fmap_pingpong_bank;
  import fmap_pingpong_bank_pkg::*;

  localparam int DATA_W = 16;
  localparam int LANES  = 64;
  localparam int DEPTH  = 37;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ROW_W  = DATA_W * LANES;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [LANES-1:0] mask_t;
  localparam mask_t ALL = '1;
  localparam mask_t NONE = '0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fmap_pingpong_bank_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  fmap_pingpong_bank #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_pass  = 0;
  int   n_total = 0;
  row_t exp_q[$];
  row_t mon_exp;
  int   mon_lane;

  function automatic row_t fill(input logic [DATA_W-1:0] w);
    row_t r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = w;
    return r;
  endfunction

  // Scoreboard: every rd_valid pops one expected row.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_valid_unexpected: rd_valid=1 with no read outstanding");
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.rd_data !== mon_exp) begin
          mon_lane = 0;
          for (int i = LANES - 1; i >= 0; i--)
            if (bus.rd_data[i*DATA_W +: DATA_W] !== mon_exp[i*DATA_W +: DATA_W]) mon_lane = i;
          $display("FAIL rd_data lane %0d: got %h want %h", mon_lane,
                   bus.rd_data[mon_lane*DATA_W +: DATA_W], mon_exp[mon_lane*DATA_W +: DATA_W]);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.clear_req = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_mask   = '0;
    bus.wr_last   = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_done   = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_row(input int addr, input row_t d, input mask_t m, input bit last);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(addr);
    bus.wr_data  = d;
    bus.wr_mask  = m;
    bus.wr_last  = last;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.wr_mask  = '0;
  endtask

  task automatic rd_row(input int addr, input row_t exp, input bit done);
    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(addr);
    bus.rd_done = done;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.rd_en   = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.clear_req = 1'b1;
    tick(3);
    rst = 1'b0;
    bus.clear_req = 1'b0;
    n_total++; if (bus.clear_busy !== 1'b0) $display("FAIL reset_clear_busy: got %b want 0", bus.clear_busy); else n_pass++;
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); else n_pass++;
    n_total++; if (bus.rd_data !== row_t'(0)) $display("FAIL reset_rd_data: got %h want 0", bus.rd_data[63:0]); else n_pass++;
    n_total++; if (bus.addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b want 0", bus.addr_err); else n_pass++;
    n_total++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready: got %b want 1", bus.wr_ready); else n_pass++;
    n_total++; if (bus.rd_ready !== 1'b0) $display("FAIL reset_rd_ready: got %b want 0", bus.rd_ready); else n_pass++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      wr_row(i, fill(DATA_W'(i + 1)), ALL, i == 3);
      if (i < 3) begin
        n_total++; if (bus.rd_ready !== 1'b0) $display("FAIL basic_filling_rd_ready row %0d: got %b want 0", i, bus.rd_ready); else n_pass++;
      end
    end
    n_total++; if (bus.rd_ready !== 1'b1) $display("FAIL basic_full_rd_ready: got %b want 1", bus.rd_ready); else n_pass++;
    n_total++; if (bus.wr_ready !== 1'b1) $display("FAIL basic_other_bank_wr_ready: got %b want 1", bus.wr_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_row(i, fill(DATA_W'(i + 1)), 1'b0);
      n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL basic_rd_latency row %0d: got %b want 1", i, bus.rd_valid); else n_pass++;
      n_total++; if (bus.rd_ready !== 1'b1) $display("FAIL basic_rd_ready row %0d: got %b want 1", i, bus.rd_ready); else n_pass++;
    end
    tick(1);
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL basic_rd_valid_pulse: got %b want 0", bus.rd_valid); else n_pass++;
    n_total++; if (bus.rd_data !== fill(16'h0004)) $display("FAIL basic_rd_data_hold: got %h want 0004", bus.rd_data[15:0]); else n_pass++;
  endtask

  task automatic test_full();
    wr_row(0, fill(16'h0010), ALL, 1'b0);
    wr_row(1, fill(16'h0011), ALL, 1'b1);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(2);
    bus.wr_data  = fill(16'hDEAD);
    bus.wr_mask  = ALL;
    n_total++; if (bus.wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %b want 0", bus.wr_ready); else n_pass++;
    tick(1);
    n_total++; if (bus.wr_ready !== 1'b0) $display("FAIL full_wr_ready_held: got %b want 0", bus.wr_ready); else n_pass++;
    bus.rd_done = 1'b1;
    tick(1);
    bus.rd_done  = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_mask  = '0;
    n_total++; if (bus.wr_ready !== 1'b1) $display("FAIL full_release_wr_ready: got %b want 1", bus.wr_ready); else n_pass++;
    n_total++; if (dut.wptr_q !== 1'b0) $display("FAIL full_release_wptr: got %b want 0", dut.wptr_q); else n_pass++;
    n_total++; if (bus.rd_ready !== 1'b1) $display("FAIL full_release_rd_ready: got %b want 1", bus.rd_ready); else n_pass++;
    rd_row(0, fill(16'h0010), 1'b0);
    rd_row(1, fill(16'h0011), 1'b1);
    n_total++; if (bus.rd_ready !== 1'b0) $display("FAIL full_both_empty_rd_ready: got %b want 0", bus.rd_ready); else n_pass++;
    n_total++; if (bus.wr_ready !== 1'b1) $display("FAIL full_both_empty_wr_ready: got %b want 1", bus.wr_ready); else n_pass++;
    bus.rd_done = 1'b1;
    tick(1);
    bus.rd_done = 1'b0;
    n_total++; if (dut.rptr_q !== 1'b0) $display("FAIL full_done_ignored_rptr: got %b want 0", dut.rptr_q); else n_pass++;
  endtask

  task automatic test_mask();
    row_t exp;
    exp = fill(16'hAAAA);
    exp[15:0] = 16'h5555;
    wr_row(5, fill(16'hAAAA), ALL, 1'b0);
    wr_row(5, fill(16'h5555), mask_t'(1), 1'b1);
    rd_row(5, exp, 1'b1);
    n_total++; if (bus.rd_data[15:0] !== 16'h5555) $display("FAIL mask_lane0: got %h want 5555", bus.rd_data[15:0]); else n_pass++;
    n_total++; if (bus.rd_data[ROW_W-1 -: DATA_W] !== 16'hAAAA) $display("FAIL mask_lane63: got %h want aaaa", bus.rd_data[ROW_W-1 -: DATA_W]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) wr_row(i, fill(DATA_W'(16'h20 + i)), ALL, i == 2);
    for (int i = 0; i < 2; i++) wr_row(i, fill(DATA_W'(16'h30 + i)), ALL, 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(2);
    bus.wr_data  = fill(16'h0032);
    bus.wr_mask  = ALL;
    bus.wr_last  = 1'b1;
    bus.rd_en    = 1'b1;
    bus.rd_addr  = ADDR_W'(1);
    bus.rd_done  = 1'b1;
    exp_q.push_back(fill(16'h0021));
    tick(1);
    idle_inputs();
    n_total++; if (dut.st_q[0] !== EMPTY) $display("FAIL b2b_bank0_state: got %0d want EMPTY", dut.st_q[0]); else n_pass++;
    n_total++; if (dut.st_q[1] !== FULL) $display("FAIL b2b_bank1_state: got %0d want FULL", dut.st_q[1]); else n_pass++;
    n_total++; if (dut.wptr_q !== 1'b0) $display("FAIL b2b_wptr: got %b want 0", dut.wptr_q); else n_pass++;
    n_total++; if (dut.rptr_q !== 1'b1) $display("FAIL b2b_rptr: got %b want 1", dut.rptr_q); else n_pass++;
    n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL b2b_read_with_done: got %b want 1", bus.rd_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = ADDR_W'(i);
      bus.rd_done = (i == 2);
      exp_q.push_back(fill(DATA_W'(16'h30 + i)));
      tick(1);
      n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL b2b_stream_valid %0d: got %b want 1", i, bus.rd_valid); else n_pass++;
    end
    idle_inputs();
    n_total++; if (bus.rd_ready !== 1'b0) $display("FAIL b2b_drained_rd_ready: got %b want 0", bus.rd_ready); else n_pass++;
  endtask

  task automatic test_clear();
    int n;
    wr_row(0, fill(16'h0041), ALL, 1'b0);
    wr_row(1, fill(16'h0042), ALL, 1'b0);
    wr_row(DEPTH, fill(16'h0043), ALL, 1'b1);
    n_total++; if (bus.addr_err !== 1'b1) $display("FAIL clear_oor_wr_err: got %b want 1", bus.addr_err); else n_pass++;
    n_total++; if (bus.rd_ready !== 1'b0) $display("FAIL clear_oor_wr_dropped: rd_ready got %b want 0", bus.rd_ready); else n_pass++;
    tick(3);
    n_total++; if (bus.addr_err !== 1'b1) $display("FAIL clear_err_sticky: got %b want 1", bus.addr_err); else n_pass++;

    pulse_clear();
    n_total++; if (bus.clear_busy !== 1'b1) $display("FAIL clear_busy_start: got %b want 1", bus.clear_busy); else n_pass++;
    n_total++; if (bus.addr_err !== 1'b0) $display("FAIL clear_err_cleared: got %b want 0", bus.addr_err); else n_pass++;
    n_total++; if (bus.wr_ready !== 1'b0) $display("FAIL clear_busy_wr_ready: got %b want 0", bus.wr_ready); else n_pass++;
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 4 * DEPTH) begin n++; tick(1); end
    n_total++; if (n !== DEPTH) $display("FAIL clear_busy_cycles: got %0d want %0d", n, DEPTH); else n_pass++;
    n_total++; if (bus.wr_ready !== 1'b1) $display("FAIL clear_done_wr_ready: got %b want 1", bus.wr_ready); else n_pass++;

    pulse_clear();
    tick(9);
    pulse_clear();
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 4 * DEPTH) begin n++; tick(1); end
    n_total++; if (n !== DEPTH) $display("FAIL clear_restart_cycles: got %0d want %0d", n, DEPTH); else n_pass++;

    wr_row(0, fill(16'hFFFF), NONE, 1'b1);
    rd_row(0, '0, 1'b0);
    rd_row(1, '0, 1'b0);
    rd_row(5, '0, 1'b0);
    rd_row(DEPTH - 1, '0, 1'b0);
    n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL clear_zero_read_valid: got %b want 1", bus.rd_valid); else n_pass++;

    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(DEPTH + 2);
    tick(1);
    bus.rd_en = 1'b0;
    n_total++; if (bus.rd_valid !== 1'b0) $display("FAIL clear_oor_rd_valid: got %b want 0", bus.rd_valid); else n_pass++;
    n_total++; if (bus.addr_err !== 1'b1) $display("FAIL clear_oor_rd_err: got %b want 1", bus.addr_err); else n_pass++;

    bus.rd_en   = 1'b1;
    bus.rd_addr = ADDR_W'(3);
    bus.rd_done = 1'b1;
    exp_q.push_back('0);
    tick(1);
    bus.rd_en     = 1'b0;
    bus.rd_done   = 1'b0;
    bus.clear_req = 1'b1;
    n_total++; if (bus.rd_valid !== 1'b1) $display("FAIL clear_prior_read_valid: got %b want 1", bus.rd_valid); else n_pass++;
    tick(1);
    bus.clear_req = 1'b0;
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 4 * DEPTH) begin n++; tick(1); end
    n_total++; if (n !== DEPTH) $display("FAIL clear_third_cycles: got %0d want %0d", n, DEPTH); else n_pass++;

    wr_row(0, fill(16'hFFFF), NONE, 1'b1);
    wr_row(0, fill(16'hFFFF), NONE, 1'b1);
    bus.rd_done = 1'b1;
    tick(1);
    bus.rd_done = 1'b0;
    for (int i = 0; i < 3; i++) rd_row(i, '0, i == 2);
    n_total++; if (bus.rd_ready !== 1'b0) $display("FAIL clear_bank1_drained: rd_ready got %b want 0", bus.rd_ready); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_mask();
    test_back_to_back();
    test_clear();
    tick(3);
    n_total++; if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d outstanding want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fmap_pingpong_bank.md
FMAP_PINGPONG_BANK -- requirements
Module: fmap_pingpong_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the width of one lane word.
REQ-002 The block SHALL have parameter LANES, default 64, the number of channels stored per row.
REQ-003 The block SHALL have parameter DEPTH, default 12321 (111*111), the rows per bank; ADDR_W = clog2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port clear_req, input, 1, pulse that starts zeroing both banks.
REQ-007 The block SHALL have port clear_busy, output, 1, high while zeroing is in progress.
REQ-008 The block SHALL have the write ports wr_valid (in, 1), wr_ready (out, 1), wr_addr (in, ADDR_W), wr_data (in, DATA_W*LANES, lane i at [i*DATA_W +: DATA_W]), wr_mask (in, LANES, per-lane write enable) and wr_last (in, 1, marks the final row of a map).
REQ-009 The block SHALL have the read ports rd_en (in, 1), rd_ready (out, 1), rd_addr (in, ADDR_W), rd_valid (out, 1), rd_data (out, DATA_W*LANES) and rd_done (in, 1, releases the current read bank).
REQ-010 The block SHALL have port addr_err, output, 1, sticky flag for an out-of-range access; cleared by rst or clear_req.

Function
REQ-011 The block SHALL hold two banks of DEPTH x LANES words; wptr selects the write bank and rptr selects the read bank, both 1 bit.
REQ-012 Each bank SHALL carry a state: EMPTY, FILLING or FULL.
REQ-013 wr_ready SHALL equal (bank[wptr] is EMPTY or FILLING) and not clear_busy.
REQ-014 A write SHALL occur when wr_valid and wr_ready: lanes with wr_mask=1 are written at wr_addr, lanes with wr_mask=0 are unchanged.
  - Write transitions: EMPTY to FILLING on the first write.
  - With wr_last, the bank goes to FULL and wptr toggles in the same cycle.
REQ-015 rd_ready SHALL equal bank[rptr] is FULL and not clear_busy.
REQ-016 A read SHALL occur when rd_en and rd_ready.
  - rd_data and rd_valid are registered one cycle later (latency 1).
  - rd_valid pulses for 1 cycle; rd_data holds its value when no read occurs.
REQ-017 rd_done with rd_ready SHALL set bank[rptr] to EMPTY and toggle rptr.
  - A read issued in the same cycle still completes.
  - rd_done without rd_ready is ignored.
REQ-018 wr_last and rd_done in the same cycle SHALL both take effect, acting on their own banks.
REQ-019 An access with addr >= DEPTH SHALL be dropped (no write, no rd_valid) and SHALL set addr_err.
REQ-020 When both banks are FULL, wr_ready SHALL be 0; when both are EMPTY, rd_ready SHALL be 0.
REQ-021 clear_req SHALL abort all traffic and start zeroing.
  - A row counter zeroes row n of both banks in cycle n; clear_busy stays high for exactly DEPTH cycles.
  - After clearing, both banks are EMPTY and wptr=rptr=0.
REQ-022 clear_req while clear_busy SHALL restart the counter at 0.
REQ-023 A read issued in the cycle before clear_req SHALL still deliver rd_valid.

Reset
REQ-024 rst SHALL set the following, with reset taking priority over clear_req:
  - wptr=0, rptr=0, both bank states EMPTY;
  - clear_busy=0, rd_valid=0, rd_data=0, addr_err=0.
REQ-025 rst SHALL NOT initialise the storage arrays; zeroing is done only through clear_req.

Structure
REQ-026 A shared package SHALL hold the bank-state enum (EMPTY/FILLING/FULL) and the default DATA_W, LANES and DEPTH constants.
REQ-027 One sub-module SHALL exist: fmap_bank_ram, a single-port-write, single-port-read, lane-masked RAM with registered read, instantiated twice.

Verification
REQ-028 rst, then write rows 0..3 with data 0x0001..0x0004 in all lanes, wr_last on row 3, then read rows 0..3 -> rd_valid one cycle after each rd_en, rd_data matching the written rows, rd_ready=1.
REQ-029 Fill bank 0 and bank 1, then assert wr_valid again -> wr_ready=0; rd_done once -> wr_ready=1 on the next cycle and wptr=0.
REQ-030 Write row 5 with all lanes 0xAAAA, then write row 5 with 0x5555 and wr_mask=0x...0001 -> lane0=0x5555 and lanes 1..63=0xAAAA.
REQ-031 wr_last on bank 1 and rd_done on bank 0 in the same cycle -> bank0 EMPTY, bank1 FULL, wptr=0, rptr=1.
REQ-032 wr_addr=DEPTH -> no write and addr_err=1 until clear_req; clear_req mid-fill -> clear_busy high for DEPTH cycles, then reading any row returns 0.
